// File: rtl/sot_align_ctrl_if.sv
// ----------------------------------------------------------------------------
// sot_align_ctrl_if
// Signal bundle between a sequencer (master) and the SOT alignment
// controller (slave).
//
// Request protocol: start and abort are single-cycle level requests sampled
// on the rising clock edge. There is no ready/acknowledge. A start is
// accepted only in IDLE or FAIL and is otherwise dropped. An abort is
// always accepted and wins over a start in the same cycle.
//
// Signals
//   start       master->slave  begin an alignment attempt
//   abort       master->slave  return to IDLE
//   sot_word    master->slave  registered SOT word from the capture buffer
//   bitslip_ena slave->master  capture buffer enable (0 = held cleared)
//   bitslip     slave->master  one-cycle slip pulse to the deserializer
//   busy        slave->master  alignment in progress
//   locked      slave->master  link aligned
//   fail        slave->master  ran out of slips
//   slip_count  slave->master  slips issued in the current attempt
//   lock_lost   slave->master  sticky loss-of-lock flag
//   state_dbg   slave->master  current FSM state encoding
// ----------------------------------------------------------------------------
interface sot_align_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] sot_word;
    logic       bitslip_ena;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [3:0] slip_count;
    logic       lock_lost;
    logic [2:0] state_dbg;

    modport master (
        output start, abort, sot_word,
        input  bitslip_ena, bitslip, busy, locked, fail, slip_count,
               lock_lost, state_dbg
    );

    modport slave (
        input  start, abort, sot_word,
        output bitslip_ena, bitslip, busy, locked, fail, slip_count,
               lock_lost, state_dbg
    );
endinterface

// File: rtl/sot_align_ctrl.sv
// ----------------------------------------------------------------------------
// sot_align_ctrl
// Aligns a deserialized link by comparing the captured start-of-trigger word
// against SOT_PATTERN and issuing bitslip pulses until it matches
// MATCH_COUNT times in a row. Once locked, ERR_LIMIT consecutive mismatches
// flag lock_lost and send the controller back to re-settle and re-check.
//
// Ports
//   S_AXI_ACLK    clock, rising edge
//   S_AXI_ARESET  synchronous active-high reset
//   bus           sot_align_ctrl_if.slave (requests, SOT word, status)
//
// All outputs are flops loaded from the next-state decode, so they change
// in the same cycle as the state register.
// ----------------------------------------------------------------------------
module sot_align_ctrl #(
    parameter logic [7:0] SOT_PATTERN   = 8'hF0,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 8,
    parameter int         MAX_SLIPS     = 8,
    parameter int         ERR_LIMIT     = 3
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    sot_align_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_SLIP   = 3'd4,
        S_LOCKED = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    // Terminal values: a counter at *_LAST means this cycle is the last one.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] ERR_LAST    = 8'(ERR_LIMIT - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

    state_t     state_q, state_d;
    logic [7:0] settle_q, settle_d;
    logic [7:0] match_q, match_d;
    logic [7:0] err_q, err_d;
    logic [3:0] slip_q, slip_d;
    logic       lost_q, lost_d;

    logic       ena_q, ena_d;
    logic       pulse_q, pulse_d;
    logic       busy_q, busy_d;
    logic       locked_q, locked_d;
    logic       fail_q, fail_d;

    logic       word_ok;

    assign word_ok = (bus.sot_word == SOT_PATTERN);

    // ------------------------------------------------------------------
    // Next-state, counters and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        err_d    = err_q;
        slip_d   = slip_q;
        lost_d   = lost_q;

        if (bus.abort) begin
            // lock_lost deliberately survives an abort.
            state_d  = S_IDLE;
            settle_d = 8'd0;
            match_d  = 8'd0;
            err_d    = 8'd0;
            slip_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_FAIL: begin
                    // FAIL holds slip_count until a new attempt starts.
                    if (bus.start) begin
                        state_d  = S_ENABLE;
                        settle_d = 8'd0;
                        match_d  = 8'd0;
                        err_d    = 8'd0;
                        slip_d   = 4'd0;
                        lost_d   = 1'b0;
                    end
                end
                S_ENABLE: begin
                    state_d  = S_SETTLE;
                    settle_d = 8'd0;
                end
                S_SETTLE: begin
                    if (settle_q >= SETTLE_LAST) begin
                        state_d  = S_CHECK;
                        settle_d = 8'd0;
                    end else begin
                        settle_d = settle_q + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (word_ok) begin
                        if (match_q != 8'hFF) match_d = match_q + 8'd1;
                        if (match_q >= MATCH_LAST) begin
                            state_d = S_LOCKED;
                            err_d   = 8'd0;
                        end
                    end else begin
                        match_d = 8'd0;
                        if (slip_q >= SLIP_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            // Count the slip together with its pulse so the
                            // count can never pass SLIP_MAX.
                            state_d = S_SLIP;
                            slip_d  = slip_q + 4'd1;
                        end
                    end
                end
                S_SLIP: begin
                    state_d  = S_SETTLE;
                    settle_d = 8'd0;
                end
                S_LOCKED: begin
                    if (word_ok) begin
                        err_d = 8'd0;
                    end else if (err_q >= ERR_LAST) begin
                        // Re-align without dropping the capture enable.
                        state_d  = S_SETTLE;
                        settle_d = 8'd0;
                        err_d    = 8'd0;
                        match_d  = 8'd0;
                        slip_d   = 4'd0;
                        lost_d   = 1'b1;
                    end else begin
                        err_d = err_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ena_d    = (state_d == S_ENABLE) || (state_d == S_SETTLE) ||
                   (state_d == S_CHECK)  || (state_d == S_SLIP)   ||
                   (state_d == S_LOCKED);
        pulse_d  = (state_d == S_SLIP);
        busy_d   = (state_d == S_ENABLE) || (state_d == S_SETTLE) ||
                   (state_d == S_CHECK)  || (state_d == S_SLIP);
        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q  <= S_IDLE;
            settle_q <= 8'd0;
            match_q  <= 8'd0;
            err_q    <= 8'd0;
            slip_q   <= 4'd0;
            lost_q   <= 1'b0;
            ena_q    <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            err_q    <= err_d;
            slip_q   <= slip_d;
            lost_q   <= lost_d;
            ena_q    <= ena_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.bitslip_ena = ena_q;
    assign bus.bitslip     = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.locked      = locked_q;
    assign bus.fail        = fail_q;
    assign bus.slip_count  = slip_q;
    assign bus.lock_lost   = lost_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: doc/sot_align_ctrl.md
SOT_ALIGN_CTRL -- requirements
Module: sot_align_ctrl

Interface
REQ-001 Parameter SOT_PATTERN, default 8'hF0, is the expected start-of-trigger word once the link is aligned.
REQ-002 Parameter SETTLE_CYCLES, default 4, is the number of wait cycles after enable or slip before comparing (range 1..255).
REQ-003 Parameter MATCH_COUNT, default 8, is the number of consecutive matches required to declare lock (range 1..255).
REQ-004 Parameter MAX_SLIPS, default 8, is the number of bitslips allowed before failure (range 1..15).
REQ-005 Parameter ERR_LIMIT, default 3, is the number of consecutive mismatches while locked that declares loss of lock (range 1..255).
REQ-006 S_AXI_ACLK  in  1  single clock; all logic rising-edge.
REQ-007 S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-008 start  in  1  one-cycle request to begin alignment.
REQ-009 abort  in  1  return to IDLE; priority over start.
REQ-010 sot_word  in  8  registered SOT word from the capture buffer.
REQ-011 bitslip_ena  out  1  enables the capture buffer; 0 holds it cleared.
REQ-012 bitslip  out  1  one-cycle slip pulse to the deserializer.
REQ-013 busy  out  1  high in ENABLE, SETTLE, CHECK, SLIP.
REQ-014 locked  out  1  high only in LOCKED.
REQ-015 fail  out  1  high only in FAIL.
REQ-016 slip_count  out  4  slips issued in the current attempt.
REQ-017 lock_lost  out  1  sticky; set on loss of lock, cleared by reset or an accepted start.

Function
REQ-018 States SHALL be IDLE, ENABLE, SETTLE, CHECK, SLIP, LOCKED, FAIL; all outputs registered.
REQ-019 IDLE: bitslip_ena=0; start -> ENABLE; clear slip_count, match and error counters, lock_lost.
REQ-020 ENABLE: bitslip_ena=1 from this cycle onward; unconditional -> SETTLE next cycle.
REQ-021 SETTLE: count SETTLE_CYCLES cycles, ignoring sot_word, then -> CHECK.
REQ-022 CHECK: sot_word==SOT_PATTERN increments the match counter; on reaching MATCH_COUNT -> LOCKED.
REQ-023 CHECK mismatch: clear the match counter; if slip_count==MAX_SLIPS -> FAIL, else -> SLIP.
REQ-024 SLIP: bitslip=1 for exactly this cycle; slip_count+1; -> SETTLE.
REQ-025 LOCKED: mismatch increments the error counter, match clears it; on reaching ERR_LIMIT set lock_lost, clear slip_count and match counter, -> SETTLE. bitslip_ena stays 1.
REQ-026 FAIL: bitslip_ena=0; hold slip_count; start -> ENABLE with the same clearing as REQ-019.
REQ-027 start SHALL be ignored in ENABLE, SETTLE, CHECK, SLIP, LOCKED.
REQ-028 abort in any state SHALL go to IDLE next cycle, forcing bitslip_ena, bitslip, busy, locked, fail to 0 and slip_count to 0; lock_lost is held. abort with start in the same cycle: abort wins.
REQ-029 bitslip SHALL never be high on two consecutive cycles; the minimum spacing is SETTLE_CYCLES+2 cycles.
REQ-030 Counters SHALL saturate and never wrap; slip_count never exceeds MAX_SLIPS.
REQ-031 Lock latency from start, with zero slips and all matches, SHALL be 1+SETTLE_CYCLES+MATCH_COUNT cycles, ±1.

Reset
REQ-032 S_AXI_ARESET high at a clock edge SHALL force IDLE and drive all outputs and counters to 0 from any state, including mid-SLIP.
REQ-033 Reset SHALL take priority over abort and start.

Verification
REQ-034 The bench SHALL cover sot_word=8'hF0 constantly, start pulse: bitslip never pulses, locked=1 after 13±1 cycles, slip_count=0.
REQ-035 The bench SHALL cover a pattern matching only after 3 slips: exactly 3 bitslip pulses, each separated by ≥6 cycles, then locked=1 with slip_count=3.
REQ-036 The bench SHALL cover sot_word=8'h00 constantly: 8 slips, then fail=1, bitslip_ena=0, busy=0, slip_count=8; a further start restarts with slip_count=0.
REQ-037 The bench SHALL cover loss of lock: after lock, 2 mismatches then a match keep locked=1; 3 consecutive mismatches set lock_lost=1 and locked=0, then relock occurs with lock_lost still 1.
REQ-038 The bench SHALL cover abort during SETTLE together with start in the same cycle: IDLE next cycle, all outputs 0, start ignored.
REQ-039 The bench SHALL cover reset asserted during the SLIP cycle: next cycle bitslip=0, slip_count=0, bitslip_ena=0, lock_lost=0.
